pc_cntrl: RTL and testbench

PC_CNTRL -- requirements
Module: pc_cntrl

---
 rtl/pc_cntrl_pkg.sv | 6 +
 rtl/pc_next_calc.sv | 21 ++
 rtl/pc_cntrl.sv | 57 +++++
 tb/tb_pc_cntrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pc_cntrl_pkg.sv
// pc_cntrl_pkg: shared defaults for the program-counter controller.
package pc_cntrl_pkg;
    localparam int unsigned PC_WIDTH_DEF = 32;
    localparam int unsigned RESET_PC_DEF = 0;
    localparam int unsigned PC_INC_DEF   = 1;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC mux and adder (branch, pending branch, sequential).
module pc_next_calc
    import pc_cntrl_pkg::*;
#(
    parameter int unsigned WIDTH  = PC_WIDTH_DEF,
    parameter int unsigned PC_INC = PC_INC_DEF
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             take_br,
    input  logic             is_relative_branch,
    input  logic [WIDTH-1:0] branch_addr,
    input  logic             pend,
    input  logic [WIDTH-1:0] pend_tgt,
    output logic [WIDTH-1:0] br_tgt,
    output logic [WIDTH-1:0] pc_nxt
);
    always_comb begin
        br_tgt = is_relative_branch ? pc + branch_addr : branch_addr;
        pc_nxt = take_br ? br_tgt : pend ? pend_tgt : pc + WIDTH'(PC_INC);
    end
endmodule

// File: rtl/pc_cntrl.sv
// pc_cntrl: program counter register with stall and absolute/relative branch redirect.
// Define PC_CNTRL_BR_PENDING_EN to keep branches taken during a stall until the next enabled edge.
module pc_cntrl
    import pc_cntrl_pkg::*;
#(
    parameter int unsigned      WIDTH    = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter int unsigned      PC_INC   = PC_INC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             take_br,
    input  logic             is_relative_branch,
    input  logic [WIDTH-1:0] branch_addr,
    output logic [WIDTH-1:0] pc
);
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] pc_nxt;
    logic             pend;
    logic [WIDTH-1:0] pend_tgt;

    pc_next_calc #(.WIDTH(WIDTH), .PC_INC(PC_INC)) u_calc (
        .pc                 (pc),
        .take_br            (take_br),
        .is_relative_branch (is_relative_branch),
        .branch_addr        (branch_addr),
        .pend               (pend),
        .pend_tgt           (pend_tgt),
        .br_tgt             (br_tgt),
        .pc_nxt             (pc_nxt)
    );

    always_ff @(posedge clk)
        if (!reset)
            pc <= RESET_PC;
        else if (enable)
            pc <= pc_nxt;

`ifdef PC_CNTRL_BR_PENDING_EN
    // Target is resolved while stalled, so a relative offset uses the pc seen at sampling.
    always_ff @(posedge clk)
        if (!reset) begin
            pend     <= 1'b0;
            pend_tgt <= '0;
        end else if (!enable) begin
            if (take_br) begin
                pend     <= 1'b1;
                pend_tgt <= br_tgt;
            end
        end else
            pend <= 1'b0;
`else
    assign pend     = 1'b0;
    assign pend_tgt = '0;
`endif
endmodule

// File: tb/tb_pc_cntrl.sv
// tb_pc_cntrl: table-driven and hand-sequenced checks of pc_cntrl with an expected-pc scoreboard.
module tb_pc_cntrl;
    localparam int W = 32;
`ifdef PC_CNTRL_BR_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         take_br = 1'b0;
    logic         is_relative_branch = 1'b0;
    logic [W-1:0] branch_addr = '0;
    logic [W-1:0] pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst_n;
        logic         en;
        logic         br;
        logic         rel;
        logic [W-1:0] addr;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] pc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    pc_cntrl #(.WIDTH(W)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .take_br            (take_br),
        .is_relative_branch (is_relative_branch),
        .branch_addr        (branch_addr),
        .pc                 (pc)
    );

    always #5 clk = ~clk;

    task automatic v(input logic r, e, b, rl, input logic [W-1:0] a, x, input string nm);
        tbl.push_back('{rst_n: r, en: e, br: b, rel: rl, addr: a, exp: x, name: nm});
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty pc=%h", pc);
        end else begin
            e = sb.pop_front();
            checks++;
            if (pc !== e.pc) begin
                errors++;
                $display("FAIL %s pc=%h expected %h", e.name, pc, e.pc);
            end
        end
    endtask

    task automatic step(input logic r, e, b, rl, input logic [W-1:0] a, x, input string nm);
        reset = r;
        enable = e;
        take_br = b;
        is_relative_branch = rl;
        branch_addr = a;
        sb.push_back('{name: nm, pc: x});
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog pc=%h", pc);
        $fatal(1, "timeout");
    end

    initial begin
        v(0, 1, 1, 0, 32'd55, 32'd0, "reset_0");
        v(0, 1, 1, 1, 32'd55, 32'd0, "reset_1");
        v(1, 1, 0, 0, 32'd0, 32'd1, "seq_1");
        v(1, 1, 0, 0, 32'd0, 32'd2, "seq_2");
        v(1, 1, 0, 0, 32'd0, 32'd3, "seq_3");
        v(1, 1, 0, 0, 32'd0, 32'd4, "seq_4");
        v(1, 1, 0, 0, 32'd0, 32'd5, "seq_5");
        v(1, 1, 1, 0, 32'd3, 32'd3, "abs_br");
        v(1, 1, 0, 0, 32'd0, 32'd4, "abs_after_1");
        v(1, 1, 0, 0, 32'd0, 32'd5, "abs_after_2");
        v(1, 1, 1, 0, 32'd10, 32'd10, "abs_to_10");
        v(1, 1, 1, 1, 32'hFFFF_FFFE, 32'd8, "rel_neg2");
        v(1, 1, 1, 1, 32'd4, 32'd12, "rel_pos4");
        v(1, 1, 0, 1, 32'd999, 32'd13, "ignore_rel_addr");
        v(1, 1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "abs_all_ones");
        v(1, 1, 0, 0, 32'd0, 32'd0, "wrap_seq");
        v(1, 1, 0, 0, 32'd0, 32'd1, "after_wrap");
        v(1, 1, 1, 1, 32'hFFFF_FFFF, 32'd0, "rel_wrap");
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].rst_n, tbl[i].en, tbl[i].br, tbl[i].rel, tbl[i].addr, tbl[i].exp, tbl[i].name);

        step(1, 1, 1, 0, 32'd7, 32'd7, "stall_setup");
        step(1, 0, 0, 0, 32'd0, 32'd7, "stall_1");
        step(1, 0, 1, 0, 32'd20, 32'd7, "stall_br");
        step(1, 0, 0, 0, 32'd0, 32'd7, "stall_3");
        step(1, 1, 0, 0, 32'd0, PEND ? 32'd20 : 32'd8, "stall_resume");
        step(1, 1, 0, 0, 32'd0, PEND ? 32'd21 : 32'd9, "stall_resume_seq");

        step(1, 0, 1, 0, 32'd100, PEND ? 32'd21 : 32'd9, "prec_stall");
        step(1, 1, 1, 0, 32'd40, 32'd40, "prec_new_br");
        step(1, 1, 0, 0, 32'd0, 32'd41, "prec_seq");

        step(1, 0, 1, 0, 32'd50, 32'd41, "rstclr_stall");
        step(0, 0, 0, 0, 32'd0, 32'd0, "rstclr_reset");
        step(1, 1, 0, 0, 32'd0, 32'd1, "rstclr_resume");
        step(1, 1, 0, 0, 32'd0, 32'd2, "rstclr_seq");

        step(1, 0, 1, 1, 32'd5, 32'd2, "relpend_stall");
        step(1, 0, 0, 1, 32'd77, 32'd2, "relpend_hold");
        step(1, 1, 0, 0, 32'd0, PEND ? 32'd7 : 32'd3, "relpend_resume");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover count=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
